// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back scheduler.
package wb_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/wb_sched_if.sv
// Write-back request bus: NREQ producers offer (rd, data) and get a one-hot ready back.
interface wb_sched_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned XLEN = wb_pkg::XLEN,
    parameter int unsigned AW   = wb_pkg::AW
);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_rd;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr_i.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= int'(NREQ)) begin
                cand = cand - int'(NREQ);
            end
            if (!valid_o && req_i[cand[PW-1:0]]) begin
                valid_o               = 1'b1;
                gnt_o[cand[PW-1:0]]   = 1'b1;
                idx_o                 = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_sched.sv
// Write-back scheduler: round-robin share of the register-file write port plus RAW scoreboard.
// Define WB_BYPASS_EN to add the byp1/byp2 forwarding outputs from the write-port register.
module wb_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned XLEN = wb_pkg::XLEN,
    parameter int unsigned AW   = wb_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_sched_if.slave       req,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            busy1,
    output logic            busy2,
`ifdef WB_BYPASS_EN
    output logic            byp1,
    output logic            byp2,
    output logic [XLEN-1:0] bypd1,
    output logic [XLEN-1:0] bypd2,
`endif
    output logic            we3,
    output logic [AW-1:0]   a3,
    output logic [XLEN-1:0] wd3
);

    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned NRegs = 2 ** AW;

    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic             xfer;
    logic [AW-1:0]    sel_rd;
    logic [XLEN-1:0]  sel_data;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NRegs-1:0] busy_q, busy_d;
    logic             we3_q, we3_d;
    logic [AW-1:0]    a3_q, a3_d;
    logic [XLEN-1:0]  wd3_q, wd3_d;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req_i   (req.req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (xfer)
    );

    assign req.req_ready = gnt;

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_rd   = req.req_rd[i*AW +: AW];
                sel_data = req.req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_comb begin
        we3_d = xfer && (sel_rd != '0);
        a3_d  = xfer ? sel_rd : a3_q;
        wd3_d = xfer ? sel_data : wd3_q;
    end

    // Clear before set so an issue in the retiring cycle keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (xfer && (sel_rd != '0)) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            busy_q <= '0;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            busy_q <= busy_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
        end
    end

    assign we3 = we3_q;
    assign a3  = a3_q;
    assign wd3 = wd3_q;

`ifdef WB_BYPASS_EN
    // The write port register still holds data the register file has not absorbed yet.
    assign byp1  = we3_q && (a3_q != '0) && (a3_q == rs1);
    assign byp2  = we3_q && (a3_q != '0) && (a3_q == rs2);
    assign bypd1 = wd3_q;
    assign bypd2 = wd3_q;
    assign busy1 = busy_q[rs1] && !byp1;
    assign busy2 = busy_q[rs2] && !byp2;
`else
    assign busy1 = busy_q[rs1];
    assign busy2 = busy_q[rs2];
`endif

endmodule

// File: tb/tb_wb_sched.sv
// Directed bench for wb_sched: vector table for arbitration/output stage, then hand sequences.
module tb_wb_sched;
    import wb_pkg::*;

    logic     clk;
    logic     rst_n;
    logic     iss_valid;
    reg_idx_t iss_rd, rs1, rs2;
    logic     busy1, busy2, we3;
    reg_idx_t a3;
    word_t    wd3;
`ifdef WB_BYPASS_EN
    logic     byp1, byp2;
    word_t    bypd1, bypd2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_sched_if #(.NREQ(2), .XLEN(XLEN), .AW(AW)) bus ();

    wb_sched #(.NREQ(2), .XLEN(XLEN), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .busy1     (busy1),
        .busy2     (busy2),
`ifdef WB_BYPASS_EN
        .byp1      (byp1),
        .byp2      (byp2),
        .bypd1     (bypd1),
        .bypd2     (bypd2),
`endif
        .we3       (we3),
        .a3        (a3),
        .wd3       (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] valid;
        reg_idx_t   rd0, rd1;
        word_t      d0, d1;
        logic       iv;
        reg_idx_t   ird, q1, q2;
        logic [1:0] rdy;
        logic       b1, b2, we;
        reg_idx_t   a;
        word_t      wd;
        logic       chk_dat;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input reg_idx_t r0, input word_t d0,
                         input reg_idx_t r1, input word_t d1);
        bus.req_valid = v;
        bus.req_rd    = {r1, r0};
        bus.req_data  = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, '0, '0, '0, '0);
        iss_valid = 1'b0;
        iss_rd    = '0;
    endtask

    initial begin
        logic exp_b;
        rst_n = 1'b0;
        rs1   = '0;
        rs2   = '0;
        idle();

        //        valid  rd0 rd1 d0            d1     iv  ird q1 q2  rdy    b1 b2 we a3 wd3          chk
        vt[0]  = '{2'b00, 0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        1};
        vt[1]  = '{2'b01, 5, 0, 32'hDEADBEEF, 32'h0,  0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 32'h0,        1};
        vt[2]  = '{2'b10, 0, 3, 32'h0,        32'h33, 0, 0, 0, 0, 2'b10, 0, 0, 1, 5, 32'hDEADBEEF, 1};
        vt[3]  = '{2'b11, 1, 2, 32'h11,       32'h22, 0, 0, 0, 0, 2'b01, 0, 0, 1, 3, 32'h33,       1};
        vt[4]  = '{2'b11, 4, 2, 32'h44,       32'h22, 0, 0, 0, 0, 2'b10, 0, 0, 1, 1, 32'h11,       1};
        vt[5]  = '{2'b11, 4, 6, 32'h44,       32'h66, 0, 0, 0, 0, 2'b01, 0, 0, 1, 2, 32'h22,       1};
        vt[6]  = '{2'b11, 8, 6, 32'h88,       32'h66, 0, 0, 0, 0, 2'b10, 0, 0, 1, 4, 32'h44,       1};
        vt[7]  = '{2'b01, 8, 0, 32'h88,       32'h0,  0, 0, 0, 0, 2'b01, 0, 0, 1, 6, 32'h66,       1};
        vt[8]  = '{2'b00, 0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 2'b00, 0, 0, 1, 8, 32'h88,       1};
        vt[9]  = '{2'b00, 0, 0, 32'h0,        32'h0,  0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        0};
        vt[10] = '{2'b01, 0, 0, 32'h1234,     32'h0,  0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 32'h0,        0};
        vt[11] = '{2'b00, 0, 0, 32'h0,        32'h0,  1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 32'h0,        0};
        vt[12] = '{2'b00, 0, 0, 32'h0,        32'h0,  0, 0, 5, 0, 2'b00, 0, 0, 0, 0, 32'h0,        0};

        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vt[i].valid, vt[i].rd0, vt[i].d0, vt[i].rd1, vt[i].d1);
            iss_valid = vt[i].iv;
            iss_rd    = vt[i].ird;
            rs1       = vt[i].q1;
            rs2       = vt[i].q2;
            #2;
            check($sformatf("row%0d_ready", i), 64'(bus.req_ready), 64'(vt[i].rdy));
            check($sformatf("row%0d_busy1", i), 64'(busy1), 64'(vt[i].b1));
            check($sformatf("row%0d_busy2", i), 64'(busy2), 64'(vt[i].b2));
            check($sformatf("row%0d_we3", i), 64'(we3), 64'(vt[i].we));
            if (vt[i].chk_dat) begin
                check($sformatf("row%0d_a3", i), 64'(a3), 64'(vt[i].a));
                check($sformatf("row%0d_wd3", i), 64'(wd3), 64'(vt[i].wd));
            end
            tick();
        end

        // Scoreboard: issue rd=7, retire it three cycles later, then re-issue on the retire edge.
        idle();
        iss_valid = 1'b1; iss_rd = 7; rs1 = 7; rs2 = 0;
        #2 check("sb_pre_issue", 64'(busy1), 64'd0);
        tick();
        iss_valid = 1'b0;
        #2 check("sb_set", 64'(busy1), 64'd1);
        tick();
        #2 check("sb_hold", 64'(busy1), 64'd1);
        tick();
        drive(2'b01, 7, 32'h77, 0, 0);
        #2;
        check("sb_xfer_ready", 64'(bus.req_ready), 64'b01);
        check("sb_xfer_busy", 64'(busy1), 64'd1);
        tick();
        idle();
        #2;
        check("sb_clear", 64'(busy1), 64'd0);
        check("sb_clear_we3", 64'(we3), 64'd1);
        check("sb_clear_a3", 64'(a3), 64'd7);
        check("sb_clear_wd3", 64'(wd3), 64'h77);
        tick();
        iss_valid = 1'b1; iss_rd = 7;
        tick();
        drive(2'b10, 0, 0, 7, 32'h78);
        #2;
        check("sw_busy_before", 64'(busy1), 64'd1);
        check("sw_ready", 64'(bus.req_ready), 64'b10);
        tick();
        idle();
`ifdef WB_BYPASS_EN
        exp_b = 1'b0;
`else
        exp_b = 1'b1;
`endif
        #2;
        check("sw_set_wins", 64'(busy1), 64'(exp_b));
        check("sw_a3", 64'(a3), 64'd7);
        check("sw_wd3", 64'(wd3), 64'h78);
        tick();
        #2 check("sw_still_busy", 64'(busy1), 64'd1);

        // Async reset in the middle of a cycle with a pending request.
        drive(2'b01, 10, 32'hA0, 0, 0);
        iss_valid = 1'b1; iss_rd = 12;
        #2 check("rst_pre_ready", 64'(bus.req_ready), 64'b01);
        tick();
        idle();
        drive(2'b11, 13, 32'hD0, 11, 32'hB0);
        rs1 = 12; rs2 = 7;
        #2;
        check("rst_pre_rr", 64'(bus.req_ready), 64'b10);
        check("rst_pre_busy1", 64'(busy1), 64'd1);
        check("rst_pre_a3", 64'(a3), 64'd10);
        #1 rst_n = 1'b0;
        #1;
        check("rst_we3", 64'(we3), 64'd0);
        check("rst_a3", 64'(a3), 64'd0);
        check("rst_wd3", 64'(wd3), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_busy2", 64'(busy2), 64'd0);
        #1 rst_n = 1'b1;
        #1 check("rst_rearb", 64'(bus.req_ready), 64'b01);
        tick();
        drive(2'b10, 0, 0, 11, 32'hB0);
        #2;
        check("rst_post_a3", 64'(a3), 64'd13);
        check("rst_post_wd3", 64'(wd3), 64'hD0);
        check("rst_post_ready", 64'(bus.req_ready), 64'b10);
        tick();
        idle();
        #2 check("rst_post2_a3", 64'(a3), 64'd11);
        tick();

        // Retire rd=9 while it is re-issued: forwarding window vs. stall.
        iss_valid = 1'b1; iss_rd = 9; rs1 = 0; rs2 = 9;
        tick();
        drive(2'b01, 9, 32'h55, 0, 0);
        tick();
        idle();
        #2;
        check("byp_we3", 64'(we3), 64'd1);
        check("byp_a3", 64'(a3), 64'd9);
`ifdef WB_BYPASS_EN
        check("byp_busy2", 64'(busy2), 64'd0);
        check("byp2", 64'(byp2), 64'd1);
        check("bypd2", 64'(bypd2), 64'h55);
        check("byp1_rs0", 64'(byp1), 64'd0);
        #1 rst_n = 1'b0;
        #1;
        check("byp_rst_byp2", 64'(byp2), 64'd0);
        check("byp_rst_bypd2", 64'(bypd2), 64'd0);
        check("byp_rst_we3", 64'(we3), 64'd0);
        rst_n = 1'b1;
`else
        check("nobyp_busy2", 64'(busy2), 64'd1);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
